// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the three-stage pipeline controller: opcode
// classes (instruction bits [6:2]), ALU operation codes, write-back and
// forwarding select encodings, the memory-handshake FSM state type and
// the per-instruction decode record produced by ctrl_decoder.
package pipe_ctrl_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LUI    = 5'b01101;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FORW_RF  = 2'b00;
    localparam logic [1:0] FORW_ALU = 2'b01;
    localparam logic [1:0] FORW_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } mem_state_t;

    // Class flags are only ever set for valid words (bits[1:0] = 11).
    typedef struct packed {
        logic       valid;
        logic       is_op;
        logic       is_op_imm;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_auipc;
        logic       is_lui;
        logic       writes_rd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] f3;
        logic       f7_5;
    } instr_info_t;

endpackage

// File: rtl/pipe_ctrl_decoder.sv
// ctrl_decoder
// Purely combinational field/class decode of one 32-bit instruction word.
// Used twice by pipe_ctrl: once for the D/E word, once for the W word.
// Ports:
//   instr  in   32  instruction word
//   info   out      decoded record (validity, class flags, rd/rs1/rs2, f3, f7[5])
module ctrl_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output instr_info_t info
);

    logic unused_instr_bits;

    assign unused_instr_bits = ^{instr[31], instr[29:25]};

    // Field extraction is unconditional; class flags need a valid word so a
    // reset all-zero word decodes as a bubble.
    always_comb begin
        info      = '0;
        info.valid = (instr[1:0] == 2'b11);
        info.rd    = instr[11:7];
        info.rs1   = instr[19:15];
        info.rs2   = instr[24:20];
        info.f3    = instr[14:12];
        info.f7_5  = instr[30];
        if (info.valid) begin
            case (instr[6:2])
                OPC_OP:     info.is_op     = 1'b1;
                OPC_OP_IMM: info.is_op_imm = 1'b1;
                OPC_LOAD:   info.is_load   = 1'b1;
                OPC_STORE:  info.is_store  = 1'b1;
                OPC_BRANCH: info.is_branch = 1'b1;
                OPC_JAL:    info.is_jal    = 1'b1;
                OPC_JALR:   info.is_jalr   = 1'b1;
                OPC_AUIPC:  info.is_auipc  = 1'b1;
                OPC_LUI:    info.is_lui    = 1'b1;
                default:    info.valid     = 1'b1;
            endcase
        end
        info.writes_rd = info.is_op | info.is_op_imm | info.is_load | info.is_jal |
                         info.is_jalr | info.is_auipc | info.is_lui;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central controller of the Fetch / Decode-Execute / Memory-Writeback
// pipeline: datapath decode, forwarding, register write-enable, data-memory
// handshake with wait states and timeout, and pipeline stall/flush.
// Optional feature macro: PIPE_CTRL_PERF_EN adds wrapping 32-bit counters
// perf_stall_cnt (stall cycles) and perf_flush_cnt (flush pulses).
// Parameters:
//   MAX_WAIT  WAIT cycles tolerated before the sticky timeout error (1..255)
// Ports:
//   clk, rst (synchronous, active-low)
//   instr_d, instr_w    D/E and W instruction words
//   br_taken, dmem_ack  branch result for instr_d, memory completion
//   dmem_req, dmem_we   W memory request / store
//   A_sel, B_sel, ALUctrl         ALU operand selects and operation
//   forw_a, forw_b                forwarding selects
//   reg_wr, wb_sel                register write enable and source
//   stall, flush, mem_err         pipeline control and timeout error
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_w,
    input  logic        br_taken,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        A_sel,
    output logic        B_sel,
    output logic [3:0]  ALUctrl,
    output logic [1:0]  forw_a,
    output logic [1:0]  forw_b,
    output logic        reg_wr,
    output logic [1:0]  wb_sel,
    output logic        stall,
    output logic        flush,
    output logic        mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    instr_info_t dec_d;
    instr_info_t dec_w;
    mem_state_t  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        w_valid_q;
    logic        flush_q;
    logic        req_int;
    logic        stall_int;
    logic        flush_set;
    logic        unused_dec;

    ctrl_decoder u_dec_d (.instr(instr_d), .info(dec_d));
    ctrl_decoder u_dec_w (.instr(instr_w), .info(dec_w));

    assign unused_dec = ^{dec_d, dec_w};

    // A load in W delivers its data through the memory path, everything
    // else that writes rd through the ALU-result path.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input instr_info_t w,
                                           input logic w_valid);
        if (rs != 5'd0 && rs == w.rd && w_valid && w.writes_rd)
            return w.is_load ? FORW_MEM : FORW_ALU;
        return FORW_RF;
    endfunction

    // D/E decode; unrecognised or invalid words and reset force all zeros.
    always_comb begin
        A_sel   = 1'b0;
        B_sel   = 1'b0;
        ALUctrl = ALU_ADD;
        if (rst) begin
            if (dec_d.is_op) begin
                A_sel   = 1'b1;
                ALUctrl = {dec_d.f7_5, dec_d.f3};
            end else if (dec_d.is_op_imm) begin
                A_sel   = 1'b1;
                B_sel   = 1'b1;
                ALUctrl = {(dec_d.f3 == 3'b101) ? dec_d.f7_5 : 1'b0, dec_d.f3};
            end else if (dec_d.is_load | dec_d.is_store | dec_d.is_jalr) begin
                A_sel = 1'b1;
                B_sel = 1'b1;
            end else if (dec_d.is_branch | dec_d.is_jal | dec_d.is_auipc) begin
                B_sel = 1'b1;
            end else if (dec_d.is_lui) begin
                A_sel   = 1'b1;
                B_sel   = 1'b1;
                ALUctrl = ALU_PASS_B;
            end
        end
    end

    // Memory handshake: RUN -> WAIT on an unacknowledged request, WAIT
    // counts unacknowledged cycles and gives up into ERR, which only reset
    // leaves.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_int    = w_valid_q & (dec_w.is_load | dec_w.is_store) & (state_q != ST_ERR);
        stall_int  = (req_int & ~dmem_ack) | (state_q == ST_ERR);
        case (state_q)
            ST_RUN: begin
                if (req_int && !dmem_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == MAX_WAIT_C)
                        state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    // A shadow jump right after a flush must not re-flush; a stalled jump
    // waits until the stall drops.
    assign flush_set = (dec_d.is_jal | dec_d.is_jalr | (dec_d.is_branch & br_taken)) &
                       ~stall_int & ~flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            w_valid_q  <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            flush_q    <= flush_set;
            if (!stall_int)
                w_valid_q <= dec_d.valid & ~flush_q;
        end
    end

    // Outputs are forced low while reset is held so nothing leaks out of
    // the pipeline during reset.
    always_comb begin
        wb_sel = WB_ALU;
        if (rst && dec_w.is_load)
            wb_sel = WB_MEM;
        else if (rst && (dec_w.is_jal | dec_w.is_jalr))
            wb_sel = WB_PC4;
    end

    assign forw_a   = rst ? fwd_sel(dec_d.rs1, dec_w, w_valid_q) : FORW_RF;
    assign forw_b   = rst ? fwd_sel(dec_d.rs2, dec_w, w_valid_q) : FORW_RF;
    assign dmem_req = rst & req_int;
    assign dmem_we  = rst & dec_w.is_store;
    assign stall    = rst & stall_int;
    assign reg_wr   = rst & w_valid_q & dec_w.writes_rd & (dec_w.rd != 5'd0) & ~stall_int;
    assign flush    = rst & flush_q;
    assign mem_err  = rst & (state_q == ST_ERR);

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_q)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed bench for pipe_ctrl (MAX_WAIT = 4). A behavioural model written
// from the controller's rules is compared against every output on each
// falling clock edge; hand-computed literal expectations are checked at
// the key points of each scenario. PIPE_CTRL_PERF_EN enables the counter checks.
module tb_pipe_ctrl;

    localparam int unsigned MAXW = 4;

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] SUB4  = 32'h40518233;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00528333;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] ADDI0 = 32'h00500013;
    localparam logic [31:0] ADD1  = 32'h000000B3;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] SRAI  = 32'h4034D413;
    localparam logic [31:0] LUI   = 32'h123453B7;
    localparam logic [31:0] AUIPC = 32'h00001517;
    localparam logic [31:0] JAL   = 32'h008000EF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, instr_w;
    logic        br_taken, dmem_ack;
    logic        dmem_req, dmem_we, A_sel, B_sel, reg_wr, stall, flush, mem_err;
    logic [3:0]  ALUctrl;
    logic [1:0]  forw_a, forw_b, wb_sel;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    bit          mWValid = 1'b0;
    bit          mFlush  = 1'b0;
    bit          mErr    = 1'b0;
    int          mUnacked = 0;
    logic [31:0] mStallCnt = '0;
    logic [31:0] mFlushCnt = '0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .instr_w(instr_w),
        .br_taken(br_taken), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .A_sel(A_sel), .B_sel(B_sel), .ALUctrl(ALUctrl), .forw_a(forw_a), .forw_b(forw_b),
        .reg_wr(reg_wr), .wb_sel(wb_sel), .stall(stall), .flush(flush), .mem_err(mem_err)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic [31:0] w,
                                 input logic br, input logic ack, input logic rstv);
        @(posedge clk);
        #1;
        instr_d  = d;
        instr_w  = w;
        br_taken = br;
        dmem_ack = ack;
        rst      = rstv;
        #3;
    endtask

    function automatic bit isClass(input logic [31:0] i, input logic [4:0] opc);
        return (i[1:0] == 2'b11) && (i[6:2] == opc);
    endfunction

    function automatic bit writesRd(input logic [31:0] i);
        return isClass(i, 5'b01100) || isClass(i, 5'b00100) || isClass(i, 5'b00000) ||
               isClass(i, 5'b11011) || isClass(i, 5'b11001) || isClass(i, 5'b00101) ||
               isClass(i, 5'b01101);
    endfunction

    // Returns {A_sel, B_sel, ALUctrl} from the opcode table.
    function automatic logic [5:0] modelDecode(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 6'd0;
        case (i[6:2])
            5'b01100:                   return {2'b10, i[30], i[14:12]};
            5'b00100:                   return {2'b11, (i[14:12] == 3'b101) ? i[30] : 1'b0, i[14:12]};
            5'b00000, 5'b01000, 5'b11001: return {2'b11, 4'b0000};
            5'b11000, 5'b11011, 5'b00101: return {2'b01, 4'b0000};
            5'b01101:                   return {2'b11, 4'b1111};
            default:                    return 6'd0;
        endcase
    endfunction

    function automatic logic [1:0] fwdModel(input logic [4:0] rs, input logic [31:0] w, input bit wv);
        if (rs != 0 && rs == w[11:7] && wv && writesRd(w))
            return isClass(w, 5'b00000) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin : modelCheck
        logic [5:0] eDec;
        logic       eReq, eStall, eRegWr, eFlushSet;
        logic [1:0] eWb;
        if (checkEn) begin
            eDec   = rst ? modelDecode(instr_d) : 6'd0;
            eReq   = rst && mWValid && (isClass(instr_w, 5'b00000) || isClass(instr_w, 5'b01000)) && !mErr;
            eStall = rst && ((eReq && !dmem_ack) || mErr);
            eRegWr = rst && mWValid && writesRd(instr_w) && (instr_w[11:7] != 0) && !eStall;
            if (!rst) eWb = 2'b00;
            else if (isClass(instr_w, 5'b00000)) eWb = 2'b01;
            else if (isClass(instr_w, 5'b11011) || isClass(instr_w, 5'b11001)) eWb = 2'b10;
            else eWb = 2'b00;
            checkOutput("m_A_sel",   A_sel,   eDec[5]);
            checkOutput("m_B_sel",   B_sel,   eDec[4]);
            checkOutput("m_ALUctrl", ALUctrl, eDec[3:0]);
            checkOutput("m_forw_a",  forw_a,  rst ? fwdModel(instr_d[19:15], instr_w, mWValid) : 2'b00);
            checkOutput("m_forw_b",  forw_b,  rst ? fwdModel(instr_d[24:20], instr_w, mWValid) : 2'b00);
            checkOutput("m_reg_wr",  reg_wr,  eRegWr);
            checkOutput("m_wb_sel",  wb_sel,  eWb);
            checkOutput("m_dmem_req", dmem_req, eReq);
            checkOutput("m_dmem_we", dmem_we, rst && isClass(instr_w, 5'b01000));
            checkOutput("m_stall",   stall,   eStall);
            checkOutput("m_flush",   flush,   rst && mFlush);
            checkOutput("m_mem_err", mem_err, rst && mErr);
`ifdef PIPE_CTRL_PERF_EN
            checkOutput("m_perf_stall", perf_stall_cnt, mStallCnt);
            checkOutput("m_perf_flush", perf_flush_cnt, mFlushCnt);
`endif
            if (!rst) begin
                mWValid = 0; mFlush = 0; mErr = 0; mUnacked = 0;
                mStallCnt = '0; mFlushCnt = '0;
            end else begin
                mStallCnt = mStallCnt + 32'(eStall);
                mFlushCnt = mFlushCnt + 32'(mFlush);
                eFlushSet = !eStall && !mFlush &&
                            (isClass(instr_d, 5'b11011) || isClass(instr_d, 5'b11001) ||
                             (isClass(instr_d, 5'b11000) && br_taken));
                if (!eStall) mWValid = (instr_d[1:0] == 2'b11) && !mFlush;
                mFlush = eFlushSet;
                if (eReq && !dmem_ack) begin
                    mUnacked++;
                    if (mUnacked > int'(MAXW)) mErr = 1'b1;
                end else begin
                    mUnacked = 0;
                end
            end
        end
    end

    initial begin
        rst = 1'b0; instr_d = SUB4; instr_w = ADD3; br_taken = 1'b0; dmem_ack = 1'b0;
        checkEn = 1'b1;

        // Reset with valid words at both stages.
        applyStimulus(SUB4, ADD3, 0, 0, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_reg_wr", reg_wr, 0);
        checkOutput("rst_forw_a", forw_a, 0);
        checkOutput("rst_A_sel", A_sel, 0);
        checkOutput("rst_ALUctrl", ALUctrl, 0);
        checkOutput("rst_mem_err", mem_err, 0);
        applyStimulus(ADD3, SUB4, 0, 0, 1);
        checkOutput("post_rst_reg_wr", reg_wr, 0);

        // ALU forwarding.
        applyStimulus(SUB4, ADD3, 0, 0, 1);
        checkOutput("fwd_forw_a", forw_a, 2'b01);
        checkOutput("fwd_forw_b", forw_b, 2'b00);
        checkOutput("fwd_ALUctrl", ALUctrl, 4'b1000);
        checkOutput("fwd_B_sel", B_sel, 0);
        checkOutput("fwd_reg_wr", reg_wr, 1);
        checkOutput("fwd_wb_sel", wb_sel, 2'b00);

        // Load with three wait cycles.
        applyStimulus(LW5, SUB4, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(ADD6, LW5, 0, 0, 1);
            checkOutput("lw_wait_stall", stall, 1);
            checkOutput("lw_wait_req", dmem_req, 1);
        end
        applyStimulus(ADD6, LW5, 0, 1, 1);
        checkOutput("lw_ack_stall", stall, 0);
        checkOutput("lw_ack_reg_wr", reg_wr, 1);
        checkOutput("lw_ack_wb_sel", wb_sel, 2'b01);
        checkOutput("lw_ack_forw_a", forw_a, 2'b10);
        checkOutput("lw_ack_forw_b", forw_b, 2'b10);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("lw_perf_stall", perf_stall_cnt, 3);
`endif

        // Taken branch: one flush pulse, shadow instruction killed.
        applyStimulus(BEQ, ADD6, 1, 0, 1);
        checkOutput("beq_flush_early", flush, 0);
        applyStimulus(ADD1, BEQ, 0, 0, 1);
        checkOutput("beq_flush", flush, 1);
        applyStimulus(NOP, ADD1, 0, 0, 1);
        checkOutput("beq_flush_end", flush, 0);
        checkOutput("shadow_reg_wr", reg_wr, 0);

        // Write to x0.
        applyStimulus(ADDI0, NOP, 0, 0, 1);
        applyStimulus(ADD1, ADDI0, 0, 0, 1);
        checkOutput("x0_reg_wr", reg_wr, 0);
        checkOutput("x0_forw_a", forw_a, 0);
        checkOutput("x0_forw_b", forw_b, 0);

        // Decode of further classes.
        applyStimulus(SRAI, ADD1, 0, 0, 1);
        checkOutput("srai_ALUctrl", ALUctrl, 4'b1101);
        checkOutput("srai_B_sel", B_sel, 1);
        applyStimulus(LUI, SRAI, 0, 0, 1);
        checkOutput("lui_ALUctrl", ALUctrl, 4'b1111);
        applyStimulus(AUIPC, LUI, 0, 0, 1);
        checkOutput("auipc_A_sel", A_sel, 0);
        checkOutput("auipc_ALUctrl", ALUctrl, 4'b0000);
        applyStimulus(JAL, AUIPC, 0, 0, 1);
        applyStimulus(SW, JAL, 0, 0, 1);
        checkOutput("jal_flush", flush, 1);
        checkOutput("jal_wb_sel", wb_sel, 2'b10);
        checkOutput("jal_reg_wr", reg_wr, 1);
        applyStimulus(NOP, SW, 0, 0, 1);
        checkOutput("killed_sw_req", dmem_req, 0);

        // Jump held in D/E by a stall: flush only after the stall drops.
        applyStimulus(SW, NOP, 0, 0, 1);
        applyStimulus(JAL, SW, 0, 0, 1);
        checkOutput("stalljmp_stall", stall, 1);
        applyStimulus(JAL, SW, 0, 1, 1);
        checkOutput("stalljmp_flush0", flush, 0);
        applyStimulus(NOP, JAL, 0, 0, 1);
        checkOutput("stalljmp_flush1", flush, 1);

        // Store timeout: RUN cycle plus four WAIT cycles, then ERR.
        applyStimulus(SW, NOP, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(NOP, SW, 0, 0, 1);
            checkOutput("to_wait_stall", stall, 1);
        end
        checkOutput("to_last_wait_err", mem_err, 0);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_flush_total", perf_flush_cnt, 3);
`endif
        applyStimulus(NOP, SW, 0, 0, 1);
        checkOutput("err_mem_err", mem_err, 1);
        checkOutput("err_stall", stall, 1);
        checkOutput("err_req", dmem_req, 0);
        applyStimulus(NOP, SW, 0, 1, 1);
        checkOutput("err_sticky", mem_err, 1);
        applyStimulus(NOP, SW, 0, 0, 0);
        checkOutput("err_rst_stall", stall, 0);
        applyStimulus(NOP, SW, 0, 0, 1);
        checkOutput("err_cleared", mem_err, 0);
        checkOutput("err_cleared_req", dmem_req, 0);
`ifdef PIPE_CTRL_PERF_EN
        checkOutput("perf_stall_cleared", perf_stall_cnt, 0);
`endif

        // Reset asserted mid-WAIT.
        applyStimulus(SW, NOP, 0, 0, 1);
        applyStimulus(NOP, SW, 0, 0, 1);
        applyStimulus(NOP, SW, 0, 0, 1);
        checkOutput("midwait_stall", stall, 1);
        applyStimulus(NOP, SW, 0, 0, 0);
        checkOutput("midwait_rst_req", dmem_req, 0);
        applyStimulus(NOP, NOP, 0, 0, 1);
        checkOutput("midwait_run", stall, 0);

        // Zero-wait load.
        applyStimulus(LW5, NOP, 0, 0, 1);
        applyStimulus(ADD6, LW5, 0, 1, 1);
        checkOutput("zw_stall", stall, 0);
        checkOutput("zw_req", dmem_req, 1);
        checkOutput("zw_reg_wr", reg_wr, 1);
        checkOutput("zw_forw_a", forw_a, 2'b10);
        applyStimulus(NOP, ADD6, 0, 0, 1);

        @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
